// File: rtl/rv_mdu_pkg.sv
// +--------------------------------------------------------------------------+
// | rv_mdu_pkg : MDU op encodings, divide-sequencer states, overflow values. |
// | Revision   : 1.0                                                          |
// +--------------------------------------------------------------------------+
`default_nettype none

package rv_mdu_pkg;

   localparam int XLEN     = 32;
   localparam int MDU_OP_W = 3;

   localparam logic [MDU_OP_W-1:0] MDU_MUL    = 3'd0;
   localparam logic [MDU_OP_W-1:0] MDU_MULH   = 3'd1;
   localparam logic [MDU_OP_W-1:0] MDU_MULHSU = 3'd2;
   localparam logic [MDU_OP_W-1:0] MDU_MULHU  = 3'd3;
   localparam logic [MDU_OP_W-1:0] MDU_DIV    = 3'd4;
   localparam logic [MDU_OP_W-1:0] MDU_DIVU   = 3'd5;
   localparam logic [MDU_OP_W-1:0] MDU_REM    = 3'd6;
   localparam logic [MDU_OP_W-1:0] MDU_REMU   = 3'd7;

   typedef enum logic [1:0] {
      C_IDLE = 2'd0,
      C_BUSY = 2'd1,
      C_DONE = 2'd2
   } div_ctrl_state_e;

   // Signed MIN / -1 is answered directly instead of iterating.
   localparam logic [XLEN-1:0] DIV_OVF_A    = {1'b1, {(XLEN-1){1'b0}}};
   localparam logic [XLEN-1:0] DIV_OVF_B    = {XLEN{1'b1}};
   localparam logic [XLEN-1:0] DIV_OVF_QUOT = {1'b1, {(XLEN-1){1'b0}}};
   localparam logic [XLEN-1:0] DIV_OVF_REM  = {XLEN{1'b0}};

   function automatic logic is_div_op(input logic [MDU_OP_W-1:0] op);
      return (op == MDU_DIV) || (op == MDU_DIVU) || (op == MDU_REM) || (op == MDU_REMU);
   endfunction

   function automatic logic is_signed_op(input logic [MDU_OP_W-1:0] op);
      return (op == MDU_DIV) || (op == MDU_REM);
   endfunction

   function automatic logic is_rem_op(input logic [MDU_OP_W-1:0] op);
      return (op == MDU_REM) || (op == MDU_REMU);
   endfunction

endpackage

`default_nettype wire

// File: rtl/rv_div_cache.sv
// +--------------------------------------------------------------------------+
// | rv_div_cache : single-entry store of the last completed divide.          |
// | Revision     : 1.0                                                        |
// +--------------------------------------------------------------------------+
`default_nettype none

module rv_div_cache #(
   parameter int XLEN = rv_mdu_pkg::XLEN
) (
   input  logic            clk_i,
   input  logic            arstn_i,
   input  logic [XLEN-1:0] key_a_i,
   input  logic [XLEN-1:0] key_b_i,
   input  logic            key_sgn_i,
   input  logic            wr_i,
   input  logic [XLEN-1:0] wr_a_i,
   input  logic [XLEN-1:0] wr_b_i,
   input  logic            wr_sgn_i,
   input  logic [XLEN-1:0] wr_quot_i,
   input  logic [XLEN-1:0] wr_rem_i,
   output logic            hit_o,
   output logic [XLEN-1:0] quot_o,
   output logic [XLEN-1:0] rem_o
);

   logic            valid_q, valid_d;
   logic            sgn_q, sgn_d;
   logic [XLEN-1:0] a_q, a_d;
   logic [XLEN-1:0] b_q, b_d;
   logic [XLEN-1:0] quot_q, quot_d;
   logic [XLEN-1:0] rem_q, rem_d;

   always_comb begin
      valid_d = valid_q;
      sgn_d   = sgn_q;
      a_d     = a_q;
      b_d     = b_q;
      quot_d  = quot_q;
      rem_d   = rem_q;
      if (wr_i) begin
         valid_d = 1'b1;
         sgn_d   = wr_sgn_i;
         a_d     = wr_a_i;
         b_d     = wr_b_i;
         quot_d  = wr_quot_i;
         rem_d   = wr_rem_i;
      end
   end

   always_ff @(posedge clk_i or negedge arstn_i) begin
      if (!arstn_i) begin
         valid_q <= 1'b0;
         sgn_q   <= 1'b0;
         a_q     <= '0;
         b_q     <= '0;
         quot_q  <= '0;
         rem_q   <= '0;
      end else begin
         valid_q <= valid_d;
         sgn_q   <= sgn_d;
         a_q     <= a_d;
         b_q     <= b_d;
         quot_q  <= quot_d;
         rem_q   <= rem_d;
      end
   end

   assign hit_o  = valid_q && (a_q == key_a_i) && (b_q == key_b_i) && (sgn_q == key_sgn_i);
   assign quot_o = quot_q;
   assign rem_o  = rem_q;

endmodule

`default_nettype wire

// File: rtl/rv_div_ctrl.sv
// +--------------------------------------------------------------------------+
// | rv_div_ctrl : sequencer between execute stage and the iterative divider. |
// | Optional last-result cache enabled by macro RV_DIV_CACHE_EN.             |
// | Revision    : 1.0                                                         |
// +--------------------------------------------------------------------------+
`default_nettype none

module rv_div_ctrl #(
   parameter int XLEN = rv_mdu_pkg::XLEN
) (
   input  logic                            clk_i,
   input  logic                            arstn_i,
   input  logic                            req_i,
   input  logic [rv_mdu_pkg::MDU_OP_W-1:0] mdu_op_i,
   input  logic [XLEN-1:0]                 port_a_i,
   input  logic [XLEN-1:0]                 port_b_i,
   input  logic                            kill_i,
   input  logic                            hold_i,
   output logic [XLEN-1:0]                 result_o,
   output logic                            stall_o,
   output logic                            div_start_o,
   output logic                            div_kill_o,
   output logic                            div_keep_o,
   output logic                            div_zero_o,
   output logic [XLEN-1:0]                 div_port_a_o,
   output logic [XLEN-1:0]                 div_port_b_o,
   output logic [rv_mdu_pkg::MDU_OP_W-1:0] div_mdu_op_o,
   input  logic [XLEN-1:0]                 div_result_i,
   input  logic [XLEN-1:0]                 rem_result_i,
   input  logic                            div_stall_req_i
);

   import rv_mdu_pkg::*;

   div_ctrl_state_e       state_q, state_d;
   logic [XLEN-1:0]       a_q, a_d;
   logic [XLEN-1:0]       b_q, b_d;
   logic [MDU_OP_W-1:0]   op_q, op_d;
   logic [XLEN-1:0]       res_q, res_d;

   logic                  div_req;
   logic                  ovf;
   logic                  cache_hit;
   logic                  cache_wr;
   logic [XLEN-1:0]       cache_quot;
   logic [XLEN-1:0]       cache_rem;
   logic [XLEN-1:0]       sel_res;

   assign div_req = req_i && is_div_op(mdu_op_i);
   assign ovf     = is_signed_op(mdu_op_i) && (port_a_i == DIV_OVF_A) && (port_b_i == DIV_OVF_B);
   assign sel_res = is_rem_op(op_q) ? rem_result_i : div_result_i;

`ifdef RV_DIV_CACHE_EN
   rv_div_cache #(
      .XLEN      (XLEN)
   ) u_cache (
      .clk_i     (clk_i),
      .arstn_i   (arstn_i),
      .key_a_i   (port_a_i),
      .key_b_i   (port_b_i),
      .key_sgn_i (is_signed_op(mdu_op_i)),
      .wr_i      (cache_wr),
      .wr_a_i    (a_q),
      .wr_b_i    (b_q),
      .wr_sgn_i  (is_signed_op(op_q)),
      .wr_quot_i (div_result_i),
      .wr_rem_i  (rem_result_i),
      .hit_o     (cache_hit),
      .quot_o    (cache_quot),
      .rem_o     (cache_rem)
   );
`else
   logic unused_cache_wr;
   assign unused_cache_wr = cache_wr;
   assign cache_hit       = 1'b0;
   assign cache_quot      = '0;
   assign cache_rem       = '0;
`endif

   always_comb begin
      state_d      = state_q;
      a_d          = a_q;
      b_d          = b_q;
      op_d         = op_q;
      res_d        = res_q;
      cache_wr     = 1'b0;
      stall_o      = 1'b0;
      result_o     = '0;
      div_start_o  = 1'b0;
      div_keep_o   = 1'b0;
      div_zero_o   = 1'b0;
      div_kill_o   = kill_i;
      div_port_a_o = '0;
      div_port_b_o = '0;
      div_mdu_op_o = '0;

      case (state_q)
         C_IDLE: begin
            // A flush in the same cycle as a request suppresses acceptance.
            if (div_req && !kill_i) begin
               if (ovf) begin
                  result_o = is_rem_op(mdu_op_i) ? DIV_OVF_REM : DIV_OVF_QUOT;
               end else if (cache_hit) begin
                  result_o = is_rem_op(mdu_op_i) ? cache_rem : cache_quot;
               end else begin
                  div_start_o  = 1'b1;
                  div_port_a_o = port_a_i;
                  div_port_b_o = port_b_i;
                  div_mdu_op_o = mdu_op_i;
                  a_d          = port_a_i;
                  b_d          = port_b_i;
                  op_d         = mdu_op_i;
                  stall_o      = 1'b1;
                  state_d      = C_BUSY;
               end
            end
         end
         C_BUSY: begin
            div_start_o  = 1'b1;
            div_keep_o   = hold_i;
            div_zero_o   = (b_q == '0);
            div_port_a_o = a_q;
            div_port_b_o = b_q;
            div_mdu_op_o = op_q;
            if (kill_i) begin
               state_d = C_IDLE;
            end else if (!div_stall_req_i) begin
               result_o = sel_res;
               res_d    = sel_res;
               cache_wr = 1'b1;
               state_d  = hold_i ? C_DONE : C_IDLE;
            end else begin
               stall_o = 1'b1;
            end
         end
         C_DONE: begin
            div_start_o  = 1'b1;
            div_keep_o   = 1'b1;
            div_port_a_o = a_q;
            div_port_b_o = b_q;
            div_mdu_op_o = op_q;
            result_o     = res_q;
            if (kill_i || !hold_i) begin
               state_d = C_IDLE;
            end
         end
         default: begin
            state_d = C_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_i or negedge arstn_i) begin
      if (!arstn_i) begin
         state_q <= C_IDLE;
         a_q     <= '0;
         b_q     <= '0;
         op_q    <= '0;
         res_q   <= '0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         op_q    <= op_d;
         res_q   <= res_d;
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_rv_div_ctrl.sv
// +--------------------------------------------------------------------------+
// | tb_rv_div_ctrl : directed vectors for rv_div_ctrl with a divider model.  |
// | Revision       : 1.0                                                      |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_rv_div_ctrl;

   localparam logic [2:0] OP_MUL  = 3'd0;
   localparam logic [2:0] OP_DIV  = 3'd4;
   localparam logic [2:0] OP_DIVU = 3'd5;
   localparam logic [2:0] OP_REM  = 3'd6;
   localparam logic [2:0] OP_REMU = 3'd7;

`ifdef RV_DIV_CACHE_EN
   localparam int CACHE_STALL = 0;
`else
   localparam int CACHE_STALL = 34;
`endif

   logic        clk;
   logic        arstn_i;
   logic        req_i;
   logic [2:0]  mdu_op_i;
   logic [31:0] port_a_i;
   logic [31:0] port_b_i;
   logic        kill_i;
   logic        hold_i;
   logic [31:0] result_o;
   logic        stall_o;
   logic        div_start_o;
   logic        div_kill_o;
   logic        div_keep_o;
   logic        div_zero_o;
   logic [31:0] div_port_a_o;
   logic [31:0] div_port_b_o;
   logic [2:0]  div_mdu_op_o;
   logic [31:0] div_result_i;
   logic [31:0] rem_result_i;
   logic        div_stall_req_i;

   int n_checks = 0;
   int n_fail   = 0;

   rv_div_ctrl #(.XLEN(32)) dut (
      .clk_i           (clk),
      .arstn_i         (arstn_i),
      .req_i           (req_i),
      .mdu_op_i        (mdu_op_i),
      .port_a_i        (port_a_i),
      .port_b_i        (port_b_i),
      .kill_i          (kill_i),
      .hold_i          (hold_i),
      .result_o        (result_o),
      .stall_o         (stall_o),
      .div_start_o     (div_start_o),
      .div_kill_o      (div_kill_o),
      .div_keep_o      (div_keep_o),
      .div_zero_o      (div_zero_o),
      .div_port_a_o    (div_port_a_o),
      .div_port_b_o    (div_port_b_o),
      .div_mdu_op_o    (div_mdu_op_o),
      .div_result_i    (div_result_i),
      .rem_result_i    (rem_result_i),
      .div_stall_req_i (div_stall_req_i)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural stand-in for rv_div: latency and results from its datasheet.
   logic        dv_run;
   int          dv_cnt;
   int          dv_lat;
   logic [31:0] dv_q;
   logic [31:0] dv_r;

   function automatic int model_lat(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      if (b == 32'd0) return 2;
      if ((op == OP_DIV || op == OP_REM) && (a[31] || b[31])) return 35;
      return 34;
   endfunction

   function automatic logic [63:0] model_qr(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      logic signed [31:0] sa, sb, sq, sr;
      if (b == 32'd0) return {32'hFFFF_FFFF, a};
      if (op == OP_DIV || op == OP_REM) begin
         sa = a;
         sb = b;
         sq = sa / sb;
         sr = sa % sb;
         return {sq, sr};
      end
      return {a / b, a % b};
   endfunction

   always @(posedge clk or negedge arstn_i) begin
      if (!arstn_i) begin
         dv_run <= 1'b0;
         dv_cnt <= 0;
         dv_lat <= 0;
         dv_q   <= '0;
         dv_r   <= '0;
      end else if (div_kill_o) begin
         dv_run <= 1'b0;
      end else if (!dv_run) begin
         if (div_start_o) begin
            dv_run       <= 1'b1;
            dv_cnt       <= 1;
            dv_lat       <= model_lat(div_mdu_op_o, div_port_a_o, div_port_b_o);
            {dv_q, dv_r} <= model_qr(div_mdu_op_o, div_port_a_o, div_port_b_o);
         end
      end else if (dv_cnt < dv_lat) begin
         dv_cnt <= dv_cnt + 1;
      end else if (!div_keep_o) begin
         dv_run <= 1'b0;
      end
   end

   assign div_stall_req_i = div_start_o && !(dv_run && dv_cnt >= dv_lat);
   assign div_result_i    = dv_q;
   assign rem_result_i    = dv_r;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] res, output int stalls,
                         output bit started, output bit keep_seen, output bit zero_seen);
      bit done;
      done      = 1'b0;
      res       = '0;
      stalls    = 0;
      started   = 1'b0;
      keep_seen = 1'b0;
      zero_seen = 1'b0;
      @(posedge clk);
      #1;
      req_i    = 1'b1;
      mdu_op_i = op;
      port_a_i = a;
      port_b_i = b;
      for (int i = 0; i < 200 && !done; i++) begin
         @(negedge clk);
         if (div_start_o) started = 1'b1;
         if (div_keep_o)  keep_seen = 1'b1;
         if (div_zero_o)  zero_seen = 1'b1;
         if (!stall_o) begin
            res  = result_o;
            done = 1'b1;
         end else begin
            stalls++;
         end
         @(posedge clk);
         #1;
      end
      if (!done) begin
         n_checks++;
         n_fail++;
         $display("FAIL timeout: op %0d still stalled after 200 cycles, expected completion", op);
      end
      req_i = 1'b0;
   endtask

   typedef struct {
      logic [2:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp_res;
      int          exp_stall;
      bit          exp_zero;
   } vec_t;

   vec_t vecs[11];

   initial begin
      logic [31:0] res;
      int          stalls;
      bit          started, keep_seen, zero_seen;

      vecs[0]  = '{OP_DIVU, 32'd100,        32'd7,          32'd14,         34, 1'b0};
      vecs[1]  = '{OP_REMU, 32'd100,        32'd9,          32'd1,          34, 1'b0};
      vecs[2]  = '{OP_REM,  32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,  35, 1'b0};
      vecs[3]  = '{OP_DIV,  32'hFFFF_FFEC,  32'd3,          32'hFFFF_FFFA,  35, 1'b0};
      vecs[4]  = '{OP_DIV,  32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  0,  1'b0};
      vecs[5]  = '{OP_REM,  32'h8000_0000,  32'hFFFF_FFFF,  32'h0000_0000,  0,  1'b0};
      vecs[6]  = '{OP_DIV,  32'd5,          32'd0,          32'hFFFF_FFFF,  2,  1'b1};
      vecs[7]  = '{OP_REMU, 32'd5,          32'd0,          32'd5,          2,  1'b1};
      vecs[8]  = '{OP_DIVU, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          34, 1'b0};
      vecs[9]  = '{OP_DIV,  32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  35, 1'b0};
      vecs[10] = '{OP_REM,  32'd7,          32'hFFFF_FFFD,  32'd1,          35, 1'b0};

      arstn_i  = 1'b0;
      req_i    = 1'b0;
      mdu_op_i = OP_DIVU;
      port_a_i = 32'hDEAD_BEEF;
      port_b_i = 32'h0000_1234;
      kill_i   = 1'b0;
      hold_i   = 1'b0;

      #2;
      check("rst_stall",  {31'd0, stall_o},     32'd0);
      check("rst_result", result_o,             32'd0);
      check("rst_start",  {31'd0, div_start_o}, 32'd0);
      check("rst_keep",   {31'd0, div_keep_o},  32'd0);
      check("rst_zero",   {31'd0, div_zero_o},  32'd0);
      check("rst_kill",   {31'd0, div_kill_o},  32'd0);
      check("rst_port_a", div_port_a_o,         32'd0);
      check("rst_port_b", div_port_b_o,         32'd0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      arstn_i = 1'b1;
      @(negedge clk);
      check("post_rst_stall", {31'd0, stall_o},     32'd0);
      check("post_rst_start", {31'd0, div_start_o}, 32'd0);

      for (int i = 0; i < 11; i++) begin
         run_op(vecs[i].op, vecs[i].a, vecs[i].b, res, stalls, started, keep_seen, zero_seen);
         check($sformatf("v%0d_result", i),  res,                                    vecs[i].exp_res);
         check($sformatf("v%0d_stalls", i),  stalls,                                 vecs[i].exp_stall);
         check($sformatf("v%0d_started", i), {31'd0, started},                       {31'd0, vecs[i].exp_stall != 0});
         check($sformatf("v%0d_keep", i),    {31'd0, keep_seen},                     32'd0);
         check($sformatf("v%0d_zero", i),    {31'd0, zero_seen},                     {31'd0, vecs[i].exp_zero});
      end

      // Non-divide op is ignored.
      run_op(OP_MUL, 32'd3, 32'd4, res, stalls, started, keep_seen, zero_seen);
      check("mul_stalls",  stalls,           32'd0);
      check("mul_started", {31'd0, started}, 32'd0);

      // DIV then REM on the same operands.
      run_op(OP_DIV, 32'd100, 32'd7, res, stalls, started, keep_seen, zero_seen);
      check("pair_div_result", res,    32'd14);
      check("pair_div_stalls", stalls, 32'd34);
      run_op(OP_REM, 32'd100, 32'd7, res, stalls, started, keep_seen, zero_seen);
      check("pair_rem_result", res,    32'd2);
      check("pair_rem_stalls", stalls, CACHE_STALL);

      // Kill at stall cycle 10.
      @(posedge clk);
      #1;
      req_i    = 1'b1;
      mdu_op_i = OP_DIVU;
      port_a_i = 32'd1000;
      port_b_i = 32'd3;
      repeat (10) begin
         @(posedge clk);
         #1;
      end
      kill_i = 1'b1;
      @(negedge clk);
      check("kill_div_kill",  {31'd0, div_kill_o}, 32'd1);
      check("kill_stall_now", {31'd0, stall_o},    32'd0);
      @(posedge clk);
      #1;
      kill_i = 1'b0;
      req_i  = 1'b0;
      @(negedge clk);
      check("kill_stall_next", {31'd0, stall_o}, 32'd0);
      check("kill_div_idle",   {31'd0, dv_run},  32'd0);
      run_op(OP_DIVU, 32'd9, 32'd3, res, stalls, started, keep_seen, zero_seen);
      check("after_kill_result", res,    32'd3);
      check("after_kill_stalls", stalls, 32'd34);

      // Downstream hold at completion.
      hold_i = 1'b1;
      run_op(OP_DIVU, 32'd50, 32'd7, res, stalls, started, keep_seen, zero_seen);
      check("hold_result", res,    32'd7);
      check("hold_stalls", stalls, 32'd34);
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         check($sformatf("hold%0d_result", k), result_o,                            32'd7);
         check($sformatf("hold%0d_stall", k),  {31'd0, stall_o},                    32'd0);
         check($sformatf("hold%0d_keep", k),   {31'd0, div_keep_o},                 32'd1);
         check($sformatf("hold%0d_finish", k), {31'd0, dv_run && dv_cnt >= dv_lat}, 32'd1);
         @(posedge clk);
         #1;
      end
      hold_i = 1'b0;
      repeat (2) begin
         @(posedge clk);
         #1;
      end
      @(negedge clk);
      check("hold_release_idle",  {31'd0, dv_run},     32'd0);
      check("hold_release_start", {31'd0, div_start_o}, 32'd0);

      // Reset in the middle of an operation.
      @(posedge clk);
      #1;
      req_i    = 1'b1;
      mdu_op_i = OP_DIVU;
      port_a_i = 32'd100;
      port_b_i = 32'd7;
      repeat (5) @(posedge clk);
      #1;
      arstn_i = 1'b0;
      req_i   = 1'b0;
      #1;
      check("mid_rst_stall",  {31'd0, stall_o},     32'd0);
      check("mid_rst_result", result_o,             32'd0);
      check("mid_rst_start",  {31'd0, div_start_o}, 32'd0);
      check("mid_rst_keep",   {31'd0, div_keep_o},  32'd0);
      check("mid_rst_port_a", div_port_a_o,         32'd0);
      check("mid_rst_op",     {29'd0, div_mdu_op_o}, 32'd0);
      check("mid_rst_div",    {31'd0, dv_run},      32'd0);
      @(negedge clk);
      arstn_i = 1'b1;
      run_op(OP_DIVU, 32'd20, 32'd4, res, stalls, started, keep_seen, zero_seen);
      check("post_mid_rst_result", res,    32'd5);
      check("post_mid_rst_stalls", stalls, 32'd34);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
